// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants for the LED-matrix input front end.
// One-hot image select codes, button bit positions, and the
// auto-cycle successor used when MATRIX_AUTO_CYCLE_EN is defined.
package matrix_pkg;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_A    = 3'b001;
    localparam logic [2:0] SEL_C    = 3'b010;
    localparam logic [2:0] SEL_R    = 3'b100;

    localparam int BTN_A = 0;
    localparam int BTN_C = 1;
    localparam int BTN_R = 2;

    // Successor in the A -> C -> R -> A rotation; "none" stays "none".
    function automatic logic [2:0] next_sel(input logic [2:0] cur);
        case (cur)
            SEL_A:   return SEL_C;
            SEL_C:   return SEL_R;
            SEL_R:   return SEL_A;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/matrix_input_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, polarity normalization, stability
// counter and a one-cycle press pulse on the released->pressed flip.
module btn_debounce #(
    parameter int DB_CYCLES  = 500000,
    parameter int DB_W       = 19,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    import matrix_pkg::*;

    // Raw level of a released button, so reset does not look like a press.
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

    logic            sync_p0;
    logic            sync_p1;
    logic            level;
    logic            stable;
    logic [DB_W-1:0] cnt;
    logic            flip;

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= RAW_IDLE;
            sync_p1 <= RAW_IDLE;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // level is 1 while pressed, whatever the board polarity.
    assign level = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;
    assign flip  = (level != stable) && (cnt == DB_W'(DB_CYCLES - 1));

    // Stability counter; the stable state follows only after DB_CYCLES
    // consecutive differing samples, and a press pulse marks the 0->1 flip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= flip & ~stable;
            if (level == stable) begin
                cnt <= '0;
            end else if (flip) begin
                cnt    <= '0;
                stable <= ~stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_input_ctrl.sv
// matrix_input_ctrl: debounced button selection with req/ack handshake,
// synchronized display enable and scroll-step tick for the 5x7 driver.
// Optional feature macro: MATRIX_AUTO_CYCLE_EN (auto-advance A->C->R
// after AUTO_TICKS scroll ticks without a press).
module matrix_input_ctrl #(
`ifdef MATRIX_AUTO_CYCLE_EN
    parameter int AUTO_TICKS     = 7,
`endif
    parameter int DB_CYCLES      = 500000,
    parameter int DB_W           = 19,
    parameter int SCROLL_CYCLES  = 33554432,
    parameter int SCROLL_W       = 26,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    input  logic       en_raw,
    output logic [2:0] sel,
    output logic       sel_req,
    input  logic       sel_ack,
    output logic       scroll_tick,
    output logic       en
);
    import matrix_pkg::*;

    logic [2:0]          press;
    logic [2:0]          win;
    logic                event_any;
    logic                handshake;
    logic                load;
    logic [2:0]          load_val;
    logic                en_p0;
    logic [SCROLL_W-1:0] scroll_cnt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .ACTIVE_LOW(BTN_ACTIVE_LOW))
        u_db_a (.clk(clk), .rst(rst), .raw(btn_raw[BTN_A]), .press(press[BTN_A]));
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .ACTIVE_LOW(BTN_ACTIVE_LOW))
        u_db_c (.clk(clk), .rst(rst), .raw(btn_raw[BTN_C]), .press(press[BTN_C]));
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .ACTIVE_LOW(BTN_ACTIVE_LOW))
        u_db_r (.clk(clk), .rst(rst), .raw(btn_raw[BTN_R]), .press(press[BTN_R]));

    // Enable switch is only synchronized; it is a level, not a button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_p0 <= 1'b0;
            en    <= 1'b0;
        end else begin
            en_p0 <= en_raw;
            en    <= en_p0;
        end
    end

    // Fixed priority among simultaneous press events: A, then C, then R.
    always_comb begin
        win = SEL_NONE;
        if (press[BTN_A])      win = SEL_A;
        else if (press[BTN_C]) win = SEL_C;
        else if (press[BTN_R]) win = SEL_R;
    end

    assign event_any = |press;
    assign handshake = sel_req & sel_ack;

`ifdef MATRIX_AUTO_CYCLE_EN
    localparam int AUTO_W = $clog2(AUTO_TICKS + 1);
    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_adv;

    assign auto_adv = scroll_tick && !event_any && (sel != SEL_NONE) &&
                      (auto_cnt == AUTO_W'(AUTO_TICKS - 1));

    // Counts scroll ticks since the last press or auto advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt <= '0;
        end else if (event_any || auto_adv) begin
            auto_cnt <= '0;
        end else if (scroll_tick) begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    assign load     = event_any | auto_adv;
    assign load_val = event_any ? win : next_sel(sel);
`else
    assign load     = event_any;
    assign load_val = win;
`endif

    // Selection register and request flag; a new event always beats an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel     <= SEL_NONE;
            sel_req <= 1'b0;
        end else if (load) begin
            sel     <= load_val;
            sel_req <= 1'b1;
        end else if (handshake) begin
            sel_req <= 1'b0;
        end
    end

    // Scroll period counter; restarts on every accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scroll_cnt  <= '0;
            scroll_tick <= 1'b0;
        end else begin
            scroll_tick <= 1'b0;
            if (handshake) begin
                scroll_cnt <= '0;
            end else if (en && (sel != SEL_NONE)) begin
                if (scroll_cnt == SCROLL_W'(SCROLL_CYCLES - 1)) begin
                    scroll_cnt  <= '0;
                    scroll_tick <= 1'b1;
                end else begin
                    scroll_cnt <= scroll_cnt + 1'b1;
                end
            end
        end
    end

endmodule
